mem_port_arbiter: RTL and testbench

Single-port memory arbiter that shares the unified 32-bit instruction/data memory between the pipeline's data-access stage, the instruction-fetch stage and an external program loader. It sits between the requesters and the memory array. It grants one transaction at a time with fixed priority plus fetch anti-starvation, sequences the memory access over a fixed read latency, and returns a one-cycle acknowledge with registered read data.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for data, fetch and loader requesters.
// Fixed priority with fetch anti-starvation; one transaction per IDLE->ISSUE->WAIT->ACK pass.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_D = 2'b01, OWN_F = 2'b10, OWN_L = 2'b11} own_e;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_e        state, state_d;
  own_e          win, lat_owner;
  logic          elig_d, elig_f, elig_l, arb;
  logic          win_we, lat_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic [SW-1:0] starve_cnt, starve_cnt_d;

  logic          mem_en_d, mem_we_d, busy_d, ack_d, cap;
  logic          d_ack_d, f_ack_d, l_ack_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, d_rdata_d, f_rdata_d, l_rdata_d;
  own_e          owner_d;

  // State register plus the transaction latch loaded at arbitration
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      lat_owner  <= OWN_NONE;
      lat_we     <= 1'b0;
    end else begin
      state      <= state_d;
      wait_cnt   <= wait_cnt_d;
      starve_cnt <= starve_cnt_d;
      if (arb) begin
        lat_owner <= win;
        lat_we    <= win_we;
      end
    end
  end

  // Arbitration and next-state
  always_comb begin
    elig_d = d_req & ~halted;
    elig_f = f_req & ~halted;
    elig_l = l_req;
    win    = OWN_NONE;
    if (elig_f && starve_cnt == STARVE_TOP) win = OWN_F;
    else if (elig_d)                        win = OWN_D;
    else if (elig_f)                        win = OWN_F;
    else if (elig_l)                        win = OWN_L;
    arb = (state == IDLE) && (win != OWN_NONE);

    win_we    = 1'b0;
    win_addr  = f_addr;
    win_wdata = '0;
    case (win)
      OWN_D: begin win_we = d_we; win_addr = d_addr; win_wdata = d_wdata; end
      OWN_L: begin win_we = l_we; win_addr = l_addr; win_wdata = l_wdata; end
      default: ;
    endcase

    state_d      = state;
    wait_cnt_d   = wait_cnt;
    starve_cnt_d = starve_cnt;
    case (state)
      IDLE: if (arb) begin
        state_d = ISSUE;
        if (win == OWN_F)                             starve_cnt_d = '0;
        else if (elig_f && starve_cnt != STARVE_TOP)  starve_cnt_d = starve_cnt + 1'b1;
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) state_d = ACK;
        else                       wait_cnt_d = wait_cnt + 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, decoded from state_d so every output is a flop
  always_comb begin
    mem_en_d    = arb;
    mem_we_d    = arb & win_we;
    mem_addr_d  = arb ? win_addr  : mem_addr;
    mem_wdata_d = arb ? win_wdata : mem_wdata;
    busy_d      = (state_d != IDLE);
    owner_d     = !busy_d ? OWN_NONE : (arb ? win : lat_owner);
    ack_d       = (state_d == ACK);
    d_ack_d     = ack_d && (lat_owner == OWN_D);
    f_ack_d     = ack_d && (lat_owner == OWN_F);
    l_ack_d     = ack_d && (lat_owner == OWN_L);
    cap         = (state == WAIT) && (state_d == ACK) && !lat_we;
    d_rdata_d   = (cap && lat_owner == OWN_D) ? mem_rdata : d_rdata;
    f_rdata_d   = (cap && lat_owner == OWN_F) ? mem_rdata : f_rdata;
    l_rdata_d   = (cap && lat_owner == OWN_L) ? mem_rdata : l_rdata;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= OWN_NONE;
      d_ack     <= 1'b0;
      f_ack     <= 1'b0;
      l_ack     <= 1'b0;
      d_rdata   <= '0;
      f_rdata   <= '0;
      l_rdata   <= '0;
    end else begin
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      owner     <= owner_d;
      d_ack     <= d_ack_d;
      f_ack     <= f_ack_d;
      l_ack     <= l_ack_d;
      d_rdata   <= d_rdata_d;
      f_rdata   <= f_rdata_d;
      l_rdata   <= l_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=1 instance for function/priority, LAT=3 instance for latency.
module tb_mem_port_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted;
  logic        d_req, d_we, f_req, l_req, l_we;
  logic [9:0]  d_addr, f_addr, l_addr;
  logic [31:0] d_wdata, l_wdata;
  logic        d_ack, f_ack, l_ack;
  logic [31:0] d_rdata, f_rdata, l_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;
  logic [1:0]  owner;

  logic        f3_req;
  logic [9:0]  f3_addr;
  logic        d3_ack, f3_ack, l3_ack, m3_en, m3_we, busy3;
  logic [31:0] d3_rdata, f3_rdata, l3_rdata, m3_wdata, m3_rdata;
  logic [9:0]  m3_addr;
  logic [1:0]  owner3;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rd1, p3a, p3b, p3c;

  int n_assert = 0;
  int n_fail   = 0;
  int n, en_cnt, exp_starve;
  logic [1:0] who;
  logic [1:0] exp_order [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(1), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(3), .STARVE_MAX(4)) u3 (
    .clk1(clk1), .rst_n(rst_n), .halted(1'b0),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0), .d_ack(d3_ack), .d_rdata(d3_rdata),
    .f_req(f3_req), .f_addr(f3_addr), .f_ack(f3_ack), .f_rdata(f3_rdata),
    .l_req(1'b0), .l_we(1'b0), .l_addr('0), .l_wdata('0), .l_ack(l3_ack), .l_rdata(l3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
    .busy(busy3), .owner(owner3)
  );

  // Memory models: LAT=1 single register, LAT=3 three-stage read pipe
  always @(posedge clk1) begin
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
      if (m3_en && m3_we)   mem3[m3_addr]  <= m3_wdata;
    end
    rd1 <= mem_en ? mem1[mem_addr] : 32'h0;
    p3a <= m3_en ? mem3[m3_addr] : 32'h0;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata = rd1;
  assign m3_rdata  = p3c;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until an ack appears (bounded); reports edges taken, mem_en cycles seen and acking port
  task automatic wait_ack(input bit sel3, output int cnt, output int ens, output logic [1:0] w);
    logic seen;
    cnt = 0;
    ens = 0;
    do begin
      tick();
      cnt++;
      if (sel3 ? m3_en : mem_en) ens++;
      seen = sel3 ? f3_ack : (d_ack | f_ack | l_ack);
    end while (!seen && cnt < 40);
    check(sel3 ? "ack3_seen" : "ack_seen", {63'b0, seen}, 64'd1);
    if (sel3)       w = f3_ack ? 2'd2 : 2'd0;
    else if (d_ack) w = 2'd1;
    else if (f_ack) w = 2'd2;
    else if (l_ack) w = 2'd3;
    else            w = 2'd0;
    if (!sel3) begin
      check("ack_onehot", {61'b0, d_ack, f_ack, l_ack},
            (w == 2'd1) ? 64'd4 : (w == 2'd2) ? 64'd2 : 64'd1);
      check("owner_at_ack", {62'b0, owner}, {62'b0, w});
    end
  endtask

  initial begin
    rst_n = 1'b0; halted = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    f3_req = 1'b0; f3_addr = '0;
    pl_en = 1'b1; pl_addr = 10'd5; pl_data = 32'h2842_0005;
    tick();
    pl_addr = 10'd3; pl_data = 32'h0000_3333;
    tick();
    pl_en = 1'b0;
    check("rst_busy_owner", {61'b0, busy, owner}, 64'd0);
    check("rst_mem", {20'b0, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    check("rst_acks", {61'b0, d_ack, f_ack, l_ack}, 64'd0);
    check("rst_rdata", {d_rdata, f_rdata | l_rdata}, 64'd0);

    // Single fetch read
    rst_n = 1'b1; f_req = 1'b1; f_addr = 10'd5;
    tick();
    check("f1_issue", {49'b0, mem_en, mem_we, mem_addr, busy, owner, f_ack}, {49'b0, 2'b10, 10'd5, 1'b1, 2'd2, 1'b0});
    tick();
    check("f1_wait", {61'b0, mem_en, busy, f_ack}, 64'b010);
    tick();
    check("f1_ack", {29'b0, busy, f_ack, f_rdata, 3'b0}, {29'b0, 2'b11, 32'h2842_0005, 3'b0});
    f_req = 1'b0;
    tick();
    check("f1_idle", {29'b0, busy, f_ack, owner, f_rdata}, {35'b0, 32'h2842_0005});

    // Data and fetch both held: anti-starvation order and throughput
    d_req = 1'b1; d_addr = 10'd3; f_req = 1'b1;
    exp_starve = 0;
    for (int i = 0; i < 10; i++) begin
      wait_ack(1'b0, n, en_cnt, who);
      check("starve_order", {62'b0, who}, {62'b0, exp_order[i]});
      if (i > 0) check("period_lat1", 64'(n), 64'd4);
      check("en_once", 64'(en_cnt), 64'd1);
      exp_starve = (exp_order[i] == 2'd2) ? 0 : ((exp_starve < 4) ? exp_starve + 1 : 4);
      check("starve_cnt", {61'b0, dut.starve_cnt}, 64'(exp_starve));
    end
    d_req = 1'b0; f_req = 1'b0;
    tick();

    // Data write of 7 then read back
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("wr_issue", {19'b0, mem_en, mem_we, owner, mem_addr, mem_wdata},
          {19'b0, 2'b11, 2'd1, 10'd7, 32'hDEAD_BEEF});
    tick();
    check("wr_wait_we", {62'b0, mem_en, mem_we}, 64'd0);
    tick();
    check("wr_ack_rdata", {31'b0, d_ack, d_rdata}, {31'b0, 1'b1, 32'h0000_3333});
    d_we = 1'b0;
    tick();
    check("rd_idle", {62'b0, busy, mem_we}, 64'd0);
    tick();
    check("rd_issue", {62'b0, mem_en, mem_we}, 64'b10);
    tick();
    tick();
    check("rd_ack_rdata", {31'b0, d_ack, d_rdata}, {31'b0, 1'b1, 32'hDEAD_BEEF});
    d_req = 1'b0;
    tick();

    // Halted: only loader eligible; release lets data in next
    halted = 1'b1; d_req = 1'b1; f_req = 1'b1; l_req = 1'b1; l_addr = 10'd5;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b0, n, en_cnt, who);
      check("halt_loader", {62'b0, who}, 64'd3);
      check("halt_starve_hold", {61'b0, dut.starve_cnt}, 64'd0);
    end
    check("l_rdata", {32'b0, l_rdata}, {32'b0, 32'h2842_0005});
    halted = 1'b0; l_req = 1'b0;
    wait_ack(1'b0, n, en_cnt, who);
    check("unhalt_data", {62'b0, who}, 64'd1);
    check("unhalt_starve", {61'b0, dut.starve_cnt}, 64'd1);
    d_req = 1'b0; f_req = 1'b0;
    tick();

    // Reset during WAIT of a fetch
    f_req = 1'b1; f_addr = 10'd5;
    tick();
    tick();
    check("pre_rst_wait", {61'b0, busy, mem_en, f_ack}, 64'b100);
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {57'b0, busy, owner, mem_en, mem_we, d_ack, f_ack, l_ack}, 64'd0);
    check("async_rst_mem", {22'b0, mem_addr, mem_wdata}, 64'd0);
    check("async_rst_rdata", {f_rdata, d_rdata}, 64'd0);
    tick();
    check("rst_no_ack", {62'b0, f_ack, busy}, 64'd0);
    rst_n = 1'b1;
    wait_ack(1'b0, n, en_cnt, who);
    check("rearb_edges", 64'(n), 64'd3);
    check("rearb_rdata", {30'b0, who, f_rdata}, {30'b0, 2'd2, 32'h2842_0005});
    f_req = 1'b0;
    tick();

    // LAT=3 latency and back-to-back period
    f3_req = 1'b1; f3_addr = 10'd5;
    wait_ack(1'b1, n, en_cnt, who);
    check("lat3_edges", 64'(n), 64'd5);
    check("lat3_en_once", 64'(en_cnt), 64'd1);
    check("lat3_rdata", {29'b0, busy3, owner3, f3_rdata}, {29'b0, 1'b1, 2'd2, 32'h2842_0005});
    wait_ack(1'b1, n, en_cnt, who);
    check("lat3_period", 64'(n), 64'd6);
    f3_req = 1'b0;
    tick();
    check("lat3_idle_others", {30'b0, busy3, d3_ack, l3_ack, 1'b0, d3_rdata | l3_rdata}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
